// File: rtl/parity_frame_tx_pkg.sv
// Shared definitions for the parity framed serial transmitter:
// FSM state encoding, frame geometry and the per-state line level helper.
package parity_frame_tx_pkg;

  localparam int DATA_BITS  = 4;
  localparam int FRAME_BITS = 7;
  localparam int TIMER_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Serial line level for a given state; IDLE and STOP both hold the line high.
  function automatic logic frame_tx_bit(input state_e                 st,
                                        input logic [DATA_BITS-1:0] data,
                                        input logic [1:0]           idx,
                                        input logic                 par);
    logic bit_v;
    case (st)
      ST_START:  bit_v = 1'b0;
      ST_DATA:   bit_v = data[idx];
      ST_PARITY: bit_v = par;
      ST_STOP:   bit_v = 1'b1;
      default:   bit_v = 1'b1;
    endcase
    return bit_v;
  endfunction

endpackage

// File: rtl/parity_frame_tx_if.sv
// Nibble handshake bus feeding the transmitter (valid/ready with 4-bit data).
interface parity_frame_tx_if;
  import parity_frame_tx_pkg::*;

  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);

endinterface

// File: rtl/parity_frame_tx_odd_parity.sv
// Odd parity generator: output makes the total count of ones (data + parity) odd.
module parity_frame_tx_odd_parity
  import parity_frame_tx_pkg::*;
(
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_parity
);

  assign o_parity = ~(^i_data);

endmodule

// File: rtl/parity_frame_tx.sv
// Framed serial transmitter: START(0), 4 data bits LSB first, parity, STOP(1).
// Every bit lasts CLKS_PER_BIT cycles; all outputs are registered and are
// computed from the next-state values so they line up with the state register.
module parity_frame_tx
  import parity_frame_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int ODD          = 1
)(
  input  logic               clk,
  input  logic               rst,
  parity_frame_tx_if.slave   bus,
  output logic               tx,
  output logic               busy,
  output logic               done,
  output logic               parity_out
);

  localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0]         LAST_IDX  = 2'(DATA_BITS - 1);
  // Even parity is the complement of the odd parity generator output.
  localparam logic               EVEN_INV  = (ODD == 0) ? 1'b1 : 1'b0;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [TIMER_W-1:0]     r_timer;
  logic [TIMER_W-1:0]     w_timer_nxt;
  logic [1:0]             r_idx;
  logic [1:0]             w_idx_nxt;
  logic [DATA_BITS-1:0]   r_data;
  logic [DATA_BITS-1:0]   w_data_nxt;
  logic                   r_par;
  logic                   w_par_nxt;
  logic                   r_tx;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_ready;
  logic                   w_tx_nxt;
  logic                   w_busy_nxt;
  logic                   w_done_nxt;
  logic                   w_ready_nxt;
  logic                   w_odd_par;
  logic                   w_par_calc;
  logic                   w_accept;
  logic                   w_tick_last;

  parity_frame_tx_odd_parity u_odd_parity (
    .i_data   (bus.in_data),
    .o_parity (w_odd_par)
  );

  assign w_par_calc  = w_odd_par ^ EVEN_INV;
  assign w_accept    = bus.in_valid & r_ready;
  assign w_tick_last = (r_timer == LAST_TICK);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, bit timer, bit index and accept latches.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    w_par_nxt   = r_par;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_START;
          w_timer_nxt = 8'd0;
          w_idx_nxt   = 2'd0;
          w_data_nxt  = bus.in_data;
          w_par_nxt   = w_par_calc;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_tick_last) begin
          w_timer_nxt = 8'd0;
          w_state_nxt = ST_DATA;
        end else begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
      ST_DATA: begin
        if (w_tick_last) begin
          w_timer_nxt = 8'd0;
          if (r_idx == LAST_IDX) begin
            w_idx_nxt   = 2'd0;
            w_state_nxt = ST_PARITY;
          end else begin
            w_idx_nxt   = r_idx + 2'd1;
          end
        end else begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
      ST_PARITY: begin
        if (w_tick_last) begin
          w_timer_nxt = 8'd0;
          w_state_nxt = ST_STOP;
        end else begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
      ST_STOP: begin
        if (w_tick_last) begin
          w_timer_nxt = 8'd0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = 8'd0;
        w_idx_nxt   = 2'd0;
      end
    endcase

    w_tx_nxt    = frame_tx_bit(w_state_nxt, w_data_nxt, w_idx_nxt, w_par_nxt);
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
    w_ready_nxt = (w_state_nxt == ST_IDLE);
    w_done_nxt  = (w_state_nxt == ST_STOP) && (w_timer_nxt == LAST_TICK);
  end

  // Datapath registers and registered outputs; reset forces the line idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= 8'd0;
      r_idx   <= 2'd0;
      r_data  <= 4'd0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_timer <= w_timer_nxt;
      r_idx   <= w_idx_nxt;
      r_data  <= w_data_nxt;
      r_par   <= w_par_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  assign tx           = r_tx;
  assign busy         = r_busy;
  assign done         = r_done;
  assign parity_out   = r_par;
  assign bus.in_ready = r_ready;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed self-checking bench for parity_frame_tx.
// dut_a: odd parity, 4 clocks/bit; dut_e: even parity, 4 clocks/bit;
// dut_1: odd parity, 1 clock/bit. Frame patterns below are hand-computed,
// bit 0 of each 7-bit pattern is the first bit on the line (START).
module tb_parity_frame_tx;
  import parity_frame_tx_pkg::*;

  localparam int CPB = 4;

  logic clk;
  logic rst;
  logic tx_a, busy_a, done_a, par_a;
  logic tx_e, busy_e, done_e, par_e;
  logic tx_1, busy_1, done_1, par_1;

  int n_checks;
  int n_pass;

  logic cap_tx   [1:64];
  logic cap_busy [1:64];
  logic cap_done [1:64];
  logic cap_rdy  [1:64];
  logic cap_par  [1:64];

  parity_frame_tx_if if_a ();
  parity_frame_tx_if if_e ();
  parity_frame_tx_if if_1 ();

  parity_frame_tx #(.CLKS_PER_BIT(CPB), .ODD(1)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a),
    .tx(tx_a), .busy(busy_a), .done(done_a), .parity_out(par_a)
  );

  parity_frame_tx #(.CLKS_PER_BIT(CPB), .ODD(0)) dut_e (
    .clk(clk), .rst(rst), .bus(if_e),
    .tx(tx_e), .busy(busy_e), .done(done_e), .parity_out(par_e)
  );

  parity_frame_tx #(.CLKS_PER_BIT(1), .ODD(1)) dut_1 (
    .clk(clk), .rst(rst), .bus(if_1),
    .tx(tx_1), .busy(busy_1), .done(done_1), .parity_out(par_1)
  );

  initial clk = 1'b0;
  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic set_in(input int sel, input logic v, input logic [3:0] d);
    case (sel)
      0: begin if_a.in_valid = v; if_a.in_data = d; end
      1: begin if_e.in_valid = v; if_e.in_data = d; end
      default: begin if_1.in_valid = v; if_1.in_data = d; end
    endcase
  endtask

  task automatic sample(input int sel, input int c);
    case (sel)
      0: begin
        cap_tx[c] = tx_a; cap_busy[c] = busy_a; cap_done[c] = done_a;
        cap_rdy[c] = if_a.in_ready; cap_par[c] = par_a;
      end
      1: begin
        cap_tx[c] = tx_e; cap_busy[c] = busy_e; cap_done[c] = done_e;
        cap_rdy[c] = if_e.in_ready; cap_par[c] = par_e;
      end
      default: begin
        cap_tx[c] = tx_1; cap_busy[c] = busy_1; cap_done[c] = done_1;
        cap_rdy[c] = if_1.in_ready; cap_par[c] = par_1;
      end
    endcase
  endtask

  // Called at a negedge: offer d, let the next posedge accept it, then scramble
  // in_data and record ncyc cycles (cycle 1 = first cycle after the accept edge).
  task automatic capture(input int sel, input logic [3:0] d, input int ncyc);
    set_in(sel, 1'b1, d);
    @(posedge clk);
    #1;
    set_in(sel, 1'b0, ~d);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      sample(sel, c);
    end
  endtask

  task automatic test_reset();
    logic [4:0] got;
    rst = 1'b0;
    set_in(0, 1'b0, 4'b0000);
    set_in(1, 1'b0, 4'b0000);
    set_in(2, 1'b0, 4'b0000);
    #1 rst = 1'b1;
    #1;
    got = {tx_a, busy_a, done_a, if_a.in_ready, par_a};
    n_checks++;
    if (got !== 5'b10010) $display("FAIL reset_a {tx,busy,done,rdy,par} got %b want 10010", got);
    else n_pass++;
    got = {tx_e, busy_e, done_e, if_e.in_ready, par_e};
    n_checks++;
    if (got !== 5'b10010) $display("FAIL reset_e {tx,busy,done,rdy,par} got %b want 10010", got);
    else n_pass++;
    got = {tx_1, busy_1, done_1, if_1.in_ready, par_1};
    n_checks++;
    if (got !== 5'b10010) $display("FAIL reset_1 {tx,busy,done,rdy,par} got %b want 10010", got);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    got = {tx_a, busy_a, done_a, if_a.in_ready, par_a};
    n_checks++;
    if (got !== 5'b10010) $display("FAIL reset_held_a {tx,busy,done,rdy,par} got %b want 10010", got);
    else n_pass++;
    rst = 1'b0;
  endtask

  // Entered right after reset release: the first frame is accepted on the first edge.
  task automatic test_odd_parity();
    logic [3:0] vin [0:1];
    logic [6:0] vf  [0:1];
    logic       vp  [0:1];
    logic [3:0] got, want;
    logic [2:0] bi;
    int len;
    vin[0] = 4'b1100; vf[0] = 7'b1111000; vp[0] = 1'b1;
    vin[1] = 4'b1011; vf[1] = 7'b1010110; vp[1] = 1'b0;
    len = FRAME_BITS * CPB;
    for (int v = 0; v < 2; v++) begin
      capture(0, vin[v], len + 1);
      for (int c = 1; c <= len + 1; c++) begin
        bi = 3'((c - 1) / CPB);
        if (c <= len) want = {vf[v][bi], 1'b1, (c == len), 1'b0};
        else          want = 4'b1001;
        got = {cap_tx[c], cap_busy[c], cap_done[c], cap_rdy[c]};
        n_checks++;
        if (got !== want)
          $display("FAIL odd_frame data=%b cycle=%0d {tx,busy,done,rdy} got %b want %b", vin[v], c, got, want);
        else n_pass++;
      end
      n_checks++;
      if (par_a !== vp[v]) $display("FAIL odd_parity_out data=%b got %b want %b", vin[v], par_a, vp[v]);
      else n_pass++;
    end
  endtask

  task automatic test_even_parity();
    logic [3:0] vin [0:1];
    logic [6:0] vf  [0:1];
    logic       vp  [0:1];
    logic [3:0] got, want;
    logic [2:0] bi;
    int len;
    vin[0] = 4'b1100; vf[0] = 7'b1011000; vp[0] = 1'b0;
    vin[1] = 4'b0001; vf[1] = 7'b1100010; vp[1] = 1'b1;
    len = FRAME_BITS * CPB;
    for (int v = 0; v < 2; v++) begin
      capture(1, vin[v], len + 1);
      for (int c = 1; c <= len + 1; c++) begin
        bi = 3'((c - 1) / CPB);
        if (c <= len) want = {vf[v][bi], 1'b1, (c == len), 1'b0};
        else          want = 4'b1001;
        got = {cap_tx[c], cap_busy[c], cap_done[c], cap_rdy[c]};
        n_checks++;
        if (got !== want)
          $display("FAIL even_frame data=%b cycle=%0d {tx,busy,done,rdy} got %b want %b", vin[v], c, got, want);
        else n_pass++;
      end
      n_checks++;
      if (par_e !== vp[v]) $display("FAIL even_parity_out data=%b got %b want %b", vin[v], par_e, vp[v]);
      else n_pass++;
    end
  endtask

  // in_valid held high across two frames; in_data changes mid-frame are ignored.
  task automatic test_back_to_back();
    logic [6:0] f1, f2;
    logic [3:0] got, want;
    logic [2:0] bi;
    int len;
    f1  = 7'b1111000;
    f2  = 7'b1010110;
    len = FRAME_BITS * CPB;
    set_in(0, 1'b1, 4'b1100);
    @(posedge clk);
    for (int c = 1; c <= 2 * len + 2; c++) begin
      @(negedge clk);
      sample(0, c);
      if (c == 5)  set_in(0, 1'b1, 4'b1011);
      if (c == 40) set_in(0, 1'b1, 4'b0000);
      if (c == 45) set_in(0, 1'b0, 4'b0000);
    end
    for (int c = 1; c <= 2 * len + 2; c++) begin
      if (c <= len) begin
        bi   = 3'((c - 1) / CPB);
        want = {f1[bi], 1'b1, (c == len), 1'b0};
      end else if (c == len + 1) begin
        want = 4'b1001;
      end else if (c <= 2 * len + 1) begin
        bi   = 3'((c - len - 2) / CPB);
        want = {f2[bi], 1'b1, (c == 2 * len + 1), 1'b0};
      end else begin
        want = 4'b1001;
      end
      got = {cap_tx[c], cap_busy[c], cap_done[c], cap_rdy[c]};
      n_checks++;
      if (got !== want)
        $display("FAIL b2b_frame cycle=%0d {tx,busy,done,rdy} got %b want %b", c, got, want);
      else n_pass++;
    end
    n_checks++;
    if (cap_par[len + 1] !== 1'b1) $display("FAIL b2b_parity1 got %b want 1", cap_par[len + 1]);
    else n_pass++;
    n_checks++;
    if (cap_par[len + 20] !== 1'b0) $display("FAIL b2b_parity2 got %b want 0", cap_par[len + 20]);
    else n_pass++;
  endtask

  // Reset in cycle 10 of a frame (data bit 1 of 1100 = 0 on the line), then a fresh frame.
  task automatic test_reset_mid_frame();
    logic [3:0] got, want;
    logic [2:0] bi;
    logic [6:0] f;
    int len;
    f   = 7'b1101100;
    len = FRAME_BITS * CPB;
    set_in(0, 1'b1, 4'b1100);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 4'b0000);
    for (int c = 1; c <= 10; c++) @(negedge clk);
    got = {tx_a, busy_a, done_a, if_a.in_ready};
    n_checks++;
    if (got !== 4'b0100) $display("FAIL midrst_before {tx,busy,done,rdy} got %b want 0100", got);
    else n_pass++;
    rst = 1'b1;
    #1;
    got = {tx_a, busy_a, done_a, if_a.in_ready};
    n_checks++;
    if (got !== 4'b1001) $display("FAIL midrst_async {tx,busy,done,rdy} got %b want 1001", got);
    else n_pass++;
    n_checks++;
    if (par_a !== 1'b0) $display("FAIL midrst_parity got %b want 0", par_a);
    else n_pass++;
    @(negedge clk);
    got = {tx_a, busy_a, done_a, if_a.in_ready};
    n_checks++;
    if (got !== 4'b1001) $display("FAIL midrst_held {tx,busy,done,rdy} got %b want 1001", got);
    else n_pass++;
    rst = 1'b0;
    capture(0, 4'b0110, len + 1);
    for (int c = 1; c <= len + 1; c++) begin
      bi = 3'((c - 1) / CPB);
      if (c <= len) want = {f[bi], 1'b1, (c == len), 1'b0};
      else          want = 4'b1001;
      got = {cap_tx[c], cap_busy[c], cap_done[c], cap_rdy[c]};
      n_checks++;
      if (got !== want)
        $display("FAIL midrst_frame cycle=%0d {tx,busy,done,rdy} got %b want %b", c, got, want);
      else n_pass++;
    end
    n_checks++;
    if (par_a !== 1'b1) $display("FAIL midrst_frame_parity got %b want 1", par_a);
    else n_pass++;
  endtask

  task automatic test_one_clk_per_bit();
    logic [3:0] vin [0:1];
    logic [6:0] vf  [0:1];
    logic       vp  [0:1];
    logic [3:0] got, want;
    logic [2:0] bi;
    vin[0] = 4'b1111; vf[0] = 7'b1111110; vp[0] = 1'b1;
    vin[1] = 4'b1011; vf[1] = 7'b1010110; vp[1] = 1'b0;
    for (int v = 0; v < 2; v++) begin
      capture(2, vin[v], FRAME_BITS + 1);
      for (int c = 1; c <= FRAME_BITS + 1; c++) begin
        bi = 3'(c - 1);
        if (c <= FRAME_BITS) want = {vf[v][bi], 1'b1, (c == FRAME_BITS), 1'b0};
        else                 want = 4'b1001;
        got = {cap_tx[c], cap_busy[c], cap_done[c], cap_rdy[c]};
        n_checks++;
        if (got !== want)
          $display("FAIL cpb1_frame data=%b cycle=%0d {tx,busy,done,rdy} got %b want %b", vin[v], c, got, want);
        else n_pass++;
      end
      n_checks++;
      if (par_1 !== vp[v]) $display("FAIL cpb1_parity_out data=%b got %b want %b", vin[v], par_1, vp[v]);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_odd_parity();
    test_even_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_one_clk_per_bit();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
